// File: rtl/ts_bram_arbiter.sv
// Single-port time-surface BRAM arbiter: buffered DVS event writes vs. classifier scan reads,
// with a starvation bound for the scan. Define TS_ARB_STATS_EN to add grant/stall counters.
module ts_bram_arbiter #(
    parameter int ADDR_BITS    = 10,
    parameter int VALUE_BITS   = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int STARVE_LIMIT = 3,
    parameter int DROP_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evt_valid,
    input  logic [ADDR_BITS-1:0]  evt_addr,
    input  logic [VALUE_BITS-1:0] evt_data,
    output logic                  evt_ready,
    input  logic                  scan_req,
    input  logic [ADDR_BITS-1:0]  scan_addr,
    output logic                  scan_gnt,
    output logic                  scan_rvalid,
    output logic [VALUE_BITS-1:0] scan_rdata,
    output logic [ADDR_BITS-1:0]  scan_raddr,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [VALUE_BITS-1:0] mem_wdata,
    input  logic [VALUE_BITS-1:0] mem_rdata,
    output logic [DROP_BITS-1:0]  drop_count,
    output logic                  busy
`ifdef TS_ARB_STATS_EN
    ,
    output logic [31:0]           stat_wr_grants,
    output logic [31:0]           stat_rd_grants,
    output logic [31:0]           stat_rd_stall
`endif
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int SC_BITS  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_BITS-1:0]  SC_MAX = SC_BITS'(STARVE_LIMIT);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [VALUE_BITS-1:0] data;
    } evt_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;

    evt_t                fifo_mem [FIFO_DEPTH];
    evt_t                head;
    logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic [SC_BITS-1:0]  starve_cnt;
    logic                fifo_empty, fifo_full;
    logic                push, pop, wr_gnt, rd_vld;
    gnt_e                gnt;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign evt_ready  = !fifo_full;
    assign push       = evt_valid && evt_ready;
    assign head       = fifo_mem[rd_ptr];

    // Grant decision depends only on registered FIFO/starve state plus scan_req.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (fifo_empty && scan_req)
                gnt = GNT_RD;
            else if (!fifo_empty && !scan_req)
                gnt = GNT_WR;
            else if (!fifo_empty && scan_req)
                gnt = (starve_cnt < SC_MAX) ? GNT_WR : GNT_RD;
        end
    end

    always_comb begin
        scan_gnt  = (gnt == GNT_RD);
        wr_gnt    = (gnt == GNT_WR);
        pop       = wr_gnt;
        mem_en    = scan_gnt || wr_gnt;
        mem_we    = wr_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_gnt) begin
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end else if (scan_gnt) begin
            mem_addr  = scan_addr;
        end
    end

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_mem[wr_ptr] <= '{addr: evt_addr, data: evt_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            drop_count <= '0;
            rd_vld     <= 1'b0;
            scan_raddr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Counts only cycles where a pending scan lost to a write.
            if (wr_gnt && scan_req)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
            if (evt_valid && !evt_ready && drop_count != '1)
                drop_count <= drop_count + 1'b1;
            rd_vld <= scan_gnt;
            if (scan_gnt)
                scan_raddr <= scan_addr;
        end
    end

    assign scan_rvalid = rd_vld;
    assign scan_rdata  = rd_vld ? mem_rdata : '0;
    assign busy        = !fifo_empty || rd_vld;

`ifdef TS_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_grants <= '0;
            stat_rd_grants <= '0;
            stat_rd_stall  <= '0;
        end else begin
            if (wr_gnt)
                stat_wr_grants <= stat_wr_grants + 32'd1;
            if (scan_gnt)
                stat_rd_grants <= stat_rd_grants + 32'd1;
            if (scan_req && !scan_gnt)
                stat_rd_stall  <= stat_rd_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ts_bram_arbiter.sv
// Bench for ts_bram_arbiter: BRAM model, queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized mixed-traffic phase.
module tb_ts_bram_arbiter;
    localparam int AB = 10, VB = 8, DEPTH = 8, LIM = 3, DB = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic          evt_valid = 1'b0;
    logic [AB-1:0] evt_addr = '0;
    logic [VB-1:0] evt_data = '0;
    logic          evt_ready;
    logic          scan_req = 1'b0;
    logic [AB-1:0] scan_addr = '0;
    logic          scan_gnt, scan_rvalid;
    logic [VB-1:0] scan_rdata;
    logic [AB-1:0] scan_raddr;
    logic          mem_en, mem_we;
    logic [AB-1:0] mem_addr;
    logic [VB-1:0] mem_wdata;
    logic [VB-1:0] mem_rdata = '0;
    logic [DB-1:0] drop_count;
    logic          busy;
`ifdef TS_ARB_STATS_EN
    logic [31:0]   stat_wr_grants, stat_rd_grants, stat_rd_stall;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ts_bram_arbiter #(.ADDR_BITS(AB), .VALUE_BITS(VB), .FIFO_DEPTH(DEPTH),
                      .STARVE_LIMIT(LIM), .DROP_BITS(DB)) dut (
        .clk(clk), .rst(rst),
        .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_data(evt_data), .evt_ready(evt_ready),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata), .scan_raddr(scan_raddr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .drop_count(drop_count), .busy(busy)
`ifdef TS_ARB_STATS_EN
        , .stat_wr_grants(stat_wr_grants), .stat_rd_grants(stat_rd_grants),
        .stat_rd_stall(stat_rd_stall)
`endif
    );

    // BRAM driven by the DUT; gold[] is the bench's own view of what memory must hold.
    logic [VB-1:0] bram [1<<AB];
    logic [VB-1:0] gold [1<<AB];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model state
    typedef struct packed {
        logic [AB-1:0] a;
        logic [VB-1:0] d;
    } ev_t;
    ev_t           q[$];
    int            denied = 0;
    bit            pv = 0;
    logic [AB-1:0] pa = '0;
    logic [VB-1:0] pd = '0;
    int            drops = 0;
    logic [31:0]   st_wr = 0, st_rd = 0, st_stall = 0;

    always @(negedge clk) begin
        int  g;
        bit  rdy;
        ev_t e;
        rdy = q.size() < DEPTH;
        g = 0;
        if (!rst) begin
            if (q.size() == 0)  g = scan_req ? 2 : 0;
            else if (!scan_req) g = 1;
            else                g = (denied < LIM) ? 1 : 2;
        end
        chk("evt_ready", 32'(evt_ready), 32'(rdy));
        chk("scan_gnt", 32'(scan_gnt), 32'(g == 2));
        chk("mem_en", 32'(mem_en), 32'(g != 0));
        chk("mem_we", 32'(mem_we), 32'(g == 1));
        if (g == 1) begin
            chk("wr_addr", 32'(mem_addr), 32'(q[0].a));
            chk("wr_data", 32'(mem_wdata), 32'(q[0].d));
        end
        if (g == 2) chk("rd_addr", 32'(mem_addr), 32'(scan_addr));
        if (rst) chk("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        chk("scan_rvalid", 32'(scan_rvalid), 32'(pv));
        if (pv) begin
            chk("scan_rdata", 32'(scan_rdata), 32'(pd));
            chk("scan_raddr", 32'(scan_raddr), 32'(pa));
        end
        chk("busy", 32'(busy), 32'(q.size() != 0 || pv));
        chk("drop_count", 32'(drop_count), 32'(drops));
`ifdef TS_ARB_STATS_EN
        chk("stat_wr", stat_wr_grants, st_wr);
        chk("stat_rd", stat_rd_grants, st_rd);
        chk("stat_stall", stat_rd_stall, st_stall);
`endif
        if (rst) begin
            q.delete();
            denied = 0; pv = 0; pa = '0; pd = '0; drops = 0;
            st_wr = 0; st_rd = 0; st_stall = 0;
        end else begin
            if (evt_valid && !rdy && drops < (1 << DB) - 1) drops++;
            if (scan_req && g != 2) st_stall++;
            if (g == 1) begin
                gold[q[0].a] = q[0].d;
                void'(q.pop_front());
                st_wr++;
            end
            pv = (g == 2);
            if (g == 2) begin
                pa = scan_addr;
                pd = gold[scan_addr];
                st_rd++;
            end
            if (evt_valid && rdy) begin
                e.a = evt_addr;
                e.d = evt_data;
                q.push_back(e);
            end
            denied = (g == 1 && scan_req) ? denied + 1 : 0;
        end
    end

    // Stimulus: inputs change 1 time unit after posedge; grant/ready/we captured at negedge.
    bit g_s, r_s, w_s;
    task automatic cyc();
        @(negedge clk);
        g_s = scan_gnt;
        r_s = evt_ready;
        w_s = mem_we;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    initial begin
        int k, grants, cycles, reads, last, gaps_bad, wr, found;
        for (int i = 0; i < (1 << AB); i++) begin
            bram[i] = VB'(i * 37 + 11);
            gold[i] = VB'(i * 37 + 11);
        end
        do_reset(2);

        // Reset state
        chk("rst_evt_ready", 32'(evt_ready), 32'd1);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid", 32'(scan_rvalid), 32'd0);
        chk("rst_rdata", 32'(scan_rdata), 32'd0);
        chk("rst_raddr", 32'(scan_raddr), 32'd0);

        // Write addr 5 = 0x7F, then read it back two cycles later
        evt_valid = 1'b1; evt_addr = 10'd5; evt_data = 8'h7F;
        cyc();
        chk("wr5_accepted", 32'(r_s), 32'd1);
        evt_valid = 1'b0;
        cyc(); cyc();
        scan_req = 1'b1; scan_addr = 10'd5;
        k = 0;
        do begin cyc(); k++; end while (!g_s && k < 20);
        scan_req = 1'b0;
        chk("rd5_grant", 32'(g_s), 32'd1);
        chk("rd5_rvalid", 32'(scan_rvalid), 32'd1);
        chk("rd5_rdata", 32'(scan_rdata), 32'h7F);
        chk("rd5_raddr", 32'(scan_raddr), 32'd5);

        // Fill the FIFO against a held scan; it first reports full on a write-grant cycle
        do_reset(1);
        evt_valid = 1'b1; scan_req = 1'b1; scan_addr = '0;
        for (k = 0; k < 200; k++) begin
            evt_addr = AB'(k + 200); evt_data = VB'($urandom);
            cyc();
            if (g_s) scan_addr = scan_addr + 1'b1;
            if (!r_s) break;
        end
        chk("full_cycle", 32'(k), 32'd29);
        chk("full_pop_same_cycle", 32'(w_s), 32'd1);
        chk("full_drop", 32'(drop_count), 32'd1);
        chk("after_full_ready", 32'(evt_ready), 32'd1);
        evt_valid = 1'b0; scan_req = 1'b0;
        repeat (12) cyc();
        chk("drained_busy", 32'(busy), 32'd0);

        // Idle contiguous scan: one grant per cycle
        grants = 0;
        scan_req = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            scan_addr = AB'(i);
            cyc();
            if (g_s) grants++;
        end
        scan_req = 1'b0;
        cyc();
        chk("idle_scan_grants", 32'(grants), 32'd1024);

        // Saturated events: W,W,W,R pattern; full scan in 4096 cycles; drops saturate
        evt_valid = 1'b1; evt_addr = AB'($urandom); evt_data = VB'($urandom);
        cyc();
        scan_req = 1'b1; scan_addr = '0;
        cycles = 0; reads = 0; last = 0; gaps_bad = 0;
        while (reads < 1024 && cycles < 5000) begin
            evt_addr = AB'($urandom); evt_data = VB'($urandom);
            cyc();
            cycles++;
            if (g_s) begin
                if (cycles - last != 4) gaps_bad++;
                last = cycles;
                reads++;
                scan_addr = scan_addr + 1'b1;
            end
        end
        chk("starve_cycles", 32'(cycles), 32'd4096);
        chk("starve_gaps", 32'(gaps_bad), 32'd0);
        chk("drop_saturated", 32'(drop_count), 32'hFF);
        evt_valid = 1'b0; scan_req = 1'b0;
        repeat (10) cyc();

        // Random mixed traffic on a small address set
        for (int i = 0; i < 3000; i++) begin
            evt_valid = ($urandom_range(0, 99) < 45);
            evt_addr  = AB'($urandom_range(0, 15));
            evt_data  = VB'($urandom);
            if (!scan_req && $urandom_range(0, 2) == 0) begin
                scan_req  = 1'b1;
                scan_addr = AB'($urandom_range(0, 15));
            end
            cyc();
            if (g_s) scan_req = 1'b0;
        end
        evt_valid = 1'b0; scan_req = 1'b0;
        repeat (10) cyc();

        // Reset with 5 buffered events and a read in flight
        do_reset(1);
        evt_valid = 1'b1; scan_req = 1'b1; scan_addr = 10'd100;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            evt_addr = AB'($urandom_range(512, 1023)); evt_data = VB'($urandom);
            cyc();
            if (g_s) scan_addr = scan_addr + 1'b1;
            if (q.size() == 5 && pv) begin found = 1; break; end
        end
        chk("midrst_setup", 32'(found), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; evt_valid = 1'b0; scan_req = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rvalid", 32'(scan_rvalid), 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);
        wr = 0;
        repeat (6) begin
            cyc();
            if (w_s) wr++;
        end
        chk("midrst_no_writes", 32'(wr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
